// File: rtl/adis_pkg.sv
// Shared constants, state encoding and address lookup for the ADIS frame sequencer.
package adis_pkg;

  localparam int unsigned FRAME_WORDS = 7;
  localparam logic [6:0]  ADDR_DUMMY  = 7'h00;

  // Burst order: XGYRO, YGYRO, ZGYRO, XACCL, YACCL, ZACCL, TEMP (entry 0 is XGYRO).
  localparam logic [FRAME_WORDS-1:0][6:0] ADDR = {
    7'h18, 7'h0E, 7'h0C, 7'h0A, 7'h08, 7'h06, 7'h04
  };

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    STALL
  } state_t;

  // Command address for transaction k; the trailing transaction only flushes the pipeline.
  function automatic logic [6:0] txn_addr(input logic [2:0] k);
    if (k >= 3'(FRAME_WORDS)) return ADDR_DUMMY;
    return ADDR[k];
  endfunction

endpackage

// File: rtl/adis_seq_timer.sv
// Loadable down-counter shared by the inter-transaction stall and the SPI timeout.
module adis_seq_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // Load has priority; counting stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/adis_frame_seq.sv
// Read-only burst sequencer: eight pipelined SPI reads yield one 7-word sensor frame.
module adis_frame_seq
  import adis_pkg::*;
#(
  parameter int STALL_CYC   = 200,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        spi_req,
  output logic        spi_wr_en,
  output logic [15:0] spi_data_tx,
  input  logic [15:0] spi_data_rx,
  input  logic        spi_done,
  output logic [15:0] frame_data,
  output logic [2:0]  frame_idx,
  output logic        frame_valid,
  output logic        frame_last,
  output logic        busy,
  output logic        err,
  output logic        overrun
);

  localparam int unsigned TMAX = (STALL_CYC > TIMEOUT_CYC) ? STALL_CYC : TIMEOUT_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] STALL_LD   = TW'(STALL_CYC);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC);
  localparam logic [2:0]    LAST_TXN   = 3'd7;

  state_t          state, state_nxt;
  logic [2:0]      k;
  logic            done_q;
  logic            done_rise;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_en;
  logic [TW-1:0]   tmr_cnt;
  logic            tmr_zero;
  logic            tmr_done;
  logic            issue_go;

  assign done_rise = spi_done & ~done_q;
  assign tmr_en    = (state == WAIT) || (state == STALL);
  // A loaded value N is consumed over exactly N cycles: the state moves on during
  // the cycle whose tick lands the count on zero.
  assign tmr_done  = tmr_zero || (tmr_cnt == TW'(1));
  assign issue_go  = (state_nxt == ISSUE) && (state != ISSUE);

  assign spi_req   = (state == ISSUE);
  assign spi_wr_en = 1'b0;
  assign busy      = (state != IDLE);

  adis_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state, timer load and timeout decode.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    err       = 1'b0;
    unique case (state)
      // frame_last is still high on the first idle cycle; a start there is an overrun.
      IDLE:  if (start && !frame_last) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = WAIT;
        tmr_load  = 1'b1;
        tmr_val   = TIMEOUT_LD;
      end
      WAIT: begin
        if (done_rise) begin
          if (k == LAST_TXN) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = STALL;
            tmr_load  = 1'b1;
            tmr_val   = STALL_LD;
          end
        end else if (tmr_done) begin
          state_nxt = IDLE;
          err       = 1'b1;
        end
      end
      STALL: if (tmr_done) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction counter, command word, done-edge register and frame outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k           <= '0;
      done_q      <= 1'b0;
      spi_data_tx <= '0;
      frame_data  <= '0;
      frame_idx   <= '0;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done_q      <= spi_done;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
      overrun     <= start && (busy || frame_last);
      if (issue_go) begin
        if (state == IDLE) begin
          k           <= '0;
          spi_data_tx <= {9'b0, txn_addr(3'd0)};
        end else begin
          spi_data_tx <= {9'b0, txn_addr(k)};
        end
      end
      if ((state == WAIT) && done_rise) begin
        if (k != LAST_TXN) k <= k + 3'd1;
        if (k != 3'd0) begin
          frame_valid <= 1'b1;
          frame_data  <= spi_data_rx;
          frame_idx   <= k - 3'd1;
          frame_last  <= (k == LAST_TXN);
        end
      end
    end
  end

endmodule

// File: tb/tb_adis_frame_seq.sv
// Randomized bench for adis_frame_seq: SPI/sensor model plus a cycle-level schedule model.
module tb_adis_frame_seq;

  localparam int STALL = 200;
  localparam int TMO   = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        spi_req;
  logic        spi_wr_en;
  logic [15:0] spi_data_tx;
  logic [15:0] spi_data_rx = '0;
  logic        spi_done = 1'b0;
  logic [15:0] frame_data;
  logic [2:0]  frame_idx;
  logic        frame_valid;
  logic        frame_last;
  logic        busy;
  logic        err;
  logic        overrun;

  adis_frame_seq #(.STALL_CYC(STALL), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .spi_req     (spi_req),
    .spi_wr_en   (spi_wr_en),
    .spi_data_tx (spi_data_tx),
    .spi_data_rx (spi_data_rx),
    .spi_done    (spi_done),
    .frame_data  (frame_data),
    .frame_idx   (frame_idx),
    .frame_valid (frame_valid),
    .frame_last  (frame_last),
    .busy        (busy),
    .err         (err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [41:0] outs;
  assign outs = {spi_req, spi_wr_en, spi_data_tx, frame_data, frame_idx,
                 frame_valid, frame_last, busy, err, overrun};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sensor register map and expected burst order.
  logic [6:0]  addr_ref [8] = '{7'h04, 7'h06, 7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h18, 7'h00};
  logic [15:0] regfile [128];
  int dur [8];
  int hold [8];
  int hang_txn = -1;
  int frame_id = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, stamped with the cycle number.
  int          req_cyc[$];
  logic [15:0] req_tx[$];
  int          val_cyc[$];
  logic [15:0] val_data[$];
  logic [2:0]  val_idx[$];
  logic        val_last[$];
  int          err_cyc[$];
  int          ovr_cyc[$];
  int          busy_cnt = 0;
  int          wr_hi = 0;
  int          tx_glitch = 0;
  int          stray_last = 0;
  logic [15:0] prev_tx = '0;

  always @(negedge clk) begin
    if (spi_req) begin
      req_cyc.push_back(cyc);
      req_tx.push_back(spi_data_tx);
    end
    if (frame_valid) begin
      val_cyc.push_back(cyc);
      val_data.push_back(frame_data);
      val_idx.push_back(frame_idx);
      val_last.push_back(frame_last);
    end
    if (frame_last && !frame_valid) stray_last++;
    if (err) err_cyc.push_back(cyc);
    if (overrun) ovr_cyc.push_back(cyc);
    if (busy) busy_cnt++;
    if (spi_wr_en) wr_hi++;
    if (rst && !spi_req && (spi_data_tx != prev_tx)) tx_glitch++;
    prev_tx = spi_data_tx;
  end

  // SPI master + sensor: answers each command after dur[j] cycles with the register
  // addressed by the previous command, holding spi_done for hold[j] cycles.
  initial begin : spi_model
    int seen, j, d, hh;
    logic [6:0]  prev;
    logic [15:0] resp;
    seen = -1;
    j    = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (spi_req) begin
        if (seen != frame_id) begin
          seen = frame_id;
          j    = 0;
        end
        d  = (j < 8) ? dur[j] : 1;
        hh = (j < 8) ? hold[j] : 1;
        resp = (j == 0) ? 16'($urandom) : regfile[prev];
        prev = spi_data_tx[6:0];
        if (j != hang_txn) begin
          repeat (d) @(negedge clk);
          spi_data_rx = resp;
          spi_done    = 1'b1;
          repeat (hh) @(negedge clk);
          spi_done    = 1'b0;
        end
        j++;
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int hang, input bit ovr, input bit rst_mid,
                           input bit hold3, input bit fixed_regs);
    int s, e, x, o1, o2, n_req, n_val, k;
    int r [9];
    int b_req, b_val, b_err, b_ovr, b_busy, b_wr, b_gl, b_sl;
    for (int i = 0; i < 8; i++) begin
      dur[i]  = $urandom_range(12, 1);
      hold[i] = hold3 ? 3 : $urandom_range(3, 1);
    end
    for (int a = 0; a < 128; a++)
      regfile[a] = fixed_regs ? (16'h1000 + 16'(a)) : 16'($urandom);
    hang_txn = hang;
    frame_id++;
    b_req = req_cyc.size();  b_val = val_cyc.size();
    b_err = err_cyc.size();  b_ovr = ovr_cyc.size();
    b_busy = busy_cnt;  b_wr = wr_hi;  b_gl = tx_glitch;  b_sl = stray_last;

    @(negedge clk);
    start = 1'b1;
    s = cyc;
    r[0] = s + 1;
    for (int i = 0; i < 8; i++) r[i+1] = r[i] + dur[i] + 1 + STALL;
    x = r[5] + dur[5] + 1 + 50;
    if (hang >= 0) begin
      n_req = hang + 1;
      n_val = (hang > 0) ? hang - 1 : 0;
      e     = r[hang] + TMO + 1;
    end else if (rst_mid) begin
      n_req = 6;
      n_val = 5;
      e     = x;
    end else begin
      n_req = 8;
      n_val = 7;
      e     = r[7] + dur[7] + 1;
    end
    o1 = r[4] + 1;
    o2 = e;
    @(negedge clk);
    start = 1'b0;

    if (ovr) begin
      wait_cyc(o1);
      pulse_start();
      wait_cyc(o2);
      pulse_start();
    end
    if (rst_mid) begin
      wait_cyc(x - 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("rst_mid_outputs", 64'(outs), '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
    end
    wait_cyc(e + 30);

    chk($sformatf("f%0d_req_count", frame_id), req_cyc.size() - b_req, n_req);
    for (int i = 0; i < n_req; i++) begin
      if (b_req + i < req_cyc.size()) begin
        chk($sformatf("f%0d_req%0d_cycle", frame_id, i), req_cyc[b_req+i], r[i]);
        chk($sformatf("f%0d_req%0d_cmd", frame_id, i), req_tx[b_req+i], {9'b0, addr_ref[i]});
      end
    end
    chk($sformatf("f%0d_valid_count", frame_id), val_cyc.size() - b_val, n_val);
    for (int i = 0; i < n_val; i++) begin
      k = i + 1;
      if (b_val + i < val_cyc.size()) begin
        chk($sformatf("f%0d_val%0d_cycle", frame_id, i), val_cyc[b_val+i], r[k] + dur[k] + 1);
        chk($sformatf("f%0d_val%0d_data", frame_id, i), val_data[b_val+i], regfile[addr_ref[i]]);
        chk($sformatf("f%0d_val%0d_idx", frame_id, i), val_idx[b_val+i], i);
        chk($sformatf("f%0d_val%0d_last", frame_id, i), val_last[b_val+i], (k == 7));
      end
    end
    chk($sformatf("f%0d_err_count", frame_id), err_cyc.size() - b_err, (hang >= 0) ? 1 : 0);
    if (hang >= 0 && b_err < err_cyc.size())
      chk($sformatf("f%0d_err_cycle", frame_id), err_cyc[b_err], r[hang] + TMO);
    chk($sformatf("f%0d_ovr_count", frame_id), ovr_cyc.size() - b_ovr, ovr ? 2 : 0);
    if (ovr && b_ovr + 1 < ovr_cyc.size()) begin
      chk($sformatf("f%0d_ovr0_cycle", frame_id), ovr_cyc[b_ovr], o1 + 1);
      chk($sformatf("f%0d_ovr1_cycle", frame_id), ovr_cyc[b_ovr+1], o2 + 1);
    end
    chk($sformatf("f%0d_busy_cycles", frame_id), busy_cnt - b_busy, e - s - 1);
    chk($sformatf("f%0d_wr_en_high", frame_id), wr_hi - b_wr, 0);
    chk($sformatf("f%0d_cmd_unstable", frame_id), tx_glitch - b_gl, 0);
    chk($sformatf("f%0d_stray_last", frame_id), stray_last - b_sl, 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs), '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(-1, 1'b0, 1'b0, 1'b0, 1'b1); // fixed 1000+addr register map
    run_frame(-1, 1'b0, 1'b0, 1'b1, 1'b0); // spi_done held 3 cycles
    run_frame( 3, 1'b0, 1'b0, 1'b0, 1'b0); // no response on txn 3
    run_frame(-1, 1'b1, 1'b0, 1'b0, 1'b0); // starts while busy / on frame_last
    run_frame(-1, 1'b0, 1'b1, 1'b0, 1'b0); // reset during stall after txn 5
    run_frame(-1, 1'b0, 1'b0, 1'b0, 1'b0); // clean frame after reset
    run_frame( 0, 1'b0, 1'b0, 1'b0, 1'b0); // first txn never answered
    run_frame( 7, 1'b0, 1'b0, 1'b1, 1'b0); // flush txn never answered

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adis_frame_seq.md
ADIS_FRAME_SEQ -- requirements
Module: adis_frame_seq

Interface
REQ-001 SHALL have parameter STALL_CYC, default 200, idle clk cycles between SPI transactions (sensor stall time).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, max clk cycles from spi_req to spi_done rising edge.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse requesting one sensor frame.
REQ-006 SHALL have port spi_req  out  1  one-cycle pulse starting one 16-bit SPI transaction.
REQ-007 SHALL have port spi_wr_en  out  1  SPI write enable; constant 0 (read-only sequencer).
REQ-008 SHALL have port spi_data_tx  out  16  SPI command word; [6:0] register address, [15:7] zero.
REQ-009 SHALL have port spi_data_rx  in  16  SPI received word, valid when spi_done rises.
REQ-010 SHALL have port spi_done  in  1  SPI completion; high for one or more cycles per transaction.
REQ-011 SHALL have port frame_data  out  16  received sensor register value.
REQ-012 SHALL have port frame_idx  out  3  word index 0..6 (XGYRO,YGYRO,ZGYRO,XACCL,YACCL,ZACCL,TEMP).
REQ-013 SHALL have port frame_valid  out  1  one-cycle strobe qualifying frame_data/frame_idx.
REQ-014 SHALL have port frame_last  out  1  high with frame_valid when frame_idx=6.
REQ-015 SHALL have ports busy, err, overrun  out  1 each  busy = frame in progress; err, overrun = one-cycle pulses.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, STALL.
REQ-017 IDLE: on start go ISSUE, txn counter k=0, busy=1.
REQ-018 ISSUE: one-cycle spi_req; spi_data_tx = ADDR[k] for k=0..6, ADDR_DUMMY for k=7; go WAIT and load timer with TIMEOUT_CYC.
REQ-019 spi_data_tx SHALL stay stable from ISSUE until the next ISSUE.
REQ-020 WAIT: rising edge of spi_done (spi_done=1 while registered copy=0) ends the transaction; level-high spi_done SHALL NOT count twice.
REQ-021 Pipelined reads: response of transaction k>=1 is register ADDR[k-1]; response of k=0 is discarded (no frame_valid).
REQ-022 For k>=1, frame_valid SHALL pulse on the clock after the spi_done rising edge, with frame_data=spi_data_rx sampled at that edge and frame_idx=k-1.
REQ-023 After the edge: if k<7 go STALL, load timer with STALL_CYC, k=k+1; if k=7 go IDLE, busy=0 on the same cycle frame_last pulses.
REQ-024 STALL: count timer to 0, then go ISSUE; exactly STALL_CYC cycles between leaving WAIT and entering ISSUE.
REQ-025 Timeout: timer reaching 0 in WAIT SHALL pulse err, return to IDLE, clear busy; no frame_last is produced for that frame.
REQ-026 start while busy=1 (including the cycle frame_last is emitted) SHALL be ignored and pulse overrun.
REQ-027 Frame period: 8 transactions, 7 frame_valid pulses, indices strictly 0..6 ascending.
REQ-028 Timer width SHALL be clog2(max(STALL_CYC,TIMEOUT_CYC)+1) bits; no wrap.

Reset
REQ-029 rst low SHALL immediately force IDLE, k=0, timer=0, done-edge register=0.
REQ-030 Reset values: spi_req=0, spi_wr_en=0, spi_data_tx=0, frame_data=0, frame_idx=0, frame_valid=0, frame_last=0, busy=0, err=0, overrun=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no further strobes; the next start begins at k=0.

Structure
REQ-032 Package adis_pkg SHALL hold ADDR[0..6] = 7'h04,06,08,0A,0C,0E,18, ADDR_DUMMY = 7'h00, frame word count 7, state enum.
REQ-033 One sub-module adis_seq_timer (loadable down-counter with zero flag) SHALL serve both stall and timeout.
REQ-034 Output spi_req/spi_wr_en/spi_data_tx SHALL connect directly to the neighbouring SPI master; spi_data_rx/spi_done come from it.

Verification
REQ-035 Reset, one start, SPI model returns 16'h1000+addr of previous command -> 7 frame_valid pulses, data 1004,1006,1008,100A,100C,100E,1018, idx 0..6, frame_last with idx 6.
REQ-036 STALL_CYC=200 -> spi_req pulses spaced exactly (SPI duration + 1 + 200) cycles; 8 spi_req per frame, spi_wr_en always 0.
REQ-037 spi_done held high 3 cycles -> one frame_valid per transaction only.
REQ-038 SPI model never raises spi_done on txn 3 -> err pulse 1023 cycles after that spi_req, busy=0, frame_valid count 2, no frame_last.
REQ-039 start during WAIT of txn 4 and on the frame_last cycle -> overrun pulse each, frame unaffected, no new frame.
REQ-040 rst low during STALL after txn 5 -> all outputs at reset values immediately; subsequent start yields a complete correct frame.
